ula_op_sequencer: RTL and testbench
===================================

// Module: ula_op_sequencer
// PURPOSE
//  Multi-cycle successor to the combinational opcode decoder: accepts one instruction per
//  valid/ready handshake, decodes it to a ULA operation, holds the ULA enabled for a
//  per-operation cycle count, then presents a completion token (with error flag) to the
//  consumer. Sits between instruction fetch and the ULA in each processing core.
//  Also keeps saturating performance counters.
// PARAMETERS
//  OPCODE_W   8   opcode width; only low 3 bits' encodings 1..5 are legal, upper bits must be 0
//  LAT_ADDSUB 1   ULA-enable cycles for ADD/SUB (>=1)
//  LAT_MUL    4   ULA-enable cycles for MUL (>=1)
//  LAT_DIV    8   ULA-enable cycles for DIV and MOD (>=1)
//  CNT_W      16  width of performance counters
// PORTS
//  clk            in   1         rising-edge clock
//  reset          in   1         asynchronous, active-high reset
//  in_valid       in   1         instruction available
//  in_opcode      in   OPCODE_W  instruction opcode
//  in_ready       out  1         sequencer can accept (combinational: state==IDLE)
//  abort          in   1         synchronous flush to IDLE
//  ula_operation  out  3         registered ULA op select
//  ula_en         out  1         ULA execute strobe, high every EXEC cycle
//  out_valid      out  1         completion token valid
//  out_err        out  1         token is for an illegal opcode (valid only with out_valid)
//  out_ready      in   1         consumer takes token
//  busy           out  1         state != IDLE
//  instr_count    out  CNT_W     completed tokens (legal and illegal)
//  err_count      out  CNT_W     completed tokens with out_err=1
// BEHAVIOUR
//  Reset: state=IDLE, ula_operation=3'b111, ula_en=0, out_valid=0, out_err=0, counters=0;
//   in_ready=1 and busy=0 while reset is held.
//  Map: 01->000 ADD, 02->001 SUB, 03->010 MUL, 04->011 DIV, 05->100 MOD, else->111 illegal.
//  FSM IDLE/EXEC/DONE:
//   IDLE: in_valid&&in_ready at edge T latches decoded op. Legal -> EXEC, ula_operation=op,
//    cycle counter loaded with LAT-1. Illegal -> DONE directly, out_err=1, ula_operation=111,
//    ula_en never asserted.
//   EXEC: ula_en=1 for exactly LAT cycles (T+1..T+LAT); ula_operation stable; counter
//    decrements; at 0 -> DONE. Legal op: first out_valid cycle is T+LAT+1.
//   DONE: out_valid=1, out_err stable, held until out_ready; on out_valid&&out_ready -> IDLE,
//    instr_count+=1, err_count+=out_err. Illegal opcode: out_valid at T+1.
//  No overlap: in_ready=0 outside IDLE; a new instruction is accepted at earliest the cycle
//   after the DONE handshake.
//  Counters saturate at all-ones; never wrap.
//  abort (any state) -> IDLE next edge: ula_en=0, out_valid=0, out_err=0,
//   ula_operation=111; no counter update, even if out_ready is high that cycle.
//   abort beats an IDLE accept (no instruction taken).
//  in_opcode sampled only at accept; later changes are ignored.
//  Async reset mid-EXEC/DONE discards the in-flight instruction; counters clear.
//  Counter width = clog2(max(LAT_*)) bits, minimum 1.
// STRUCTURE
//  ula_defs.vh (shared include): opcode constants, ULA op codes incl. 3'b111 illegal,
//   FSM state encodings, default latencies.
//  Sub-module ula_op_decoder: combinational opcode -> {ula_op, legal, lat_sel}, used by
//   this block and reusable by other cores.
//  Top: FSM, cycle down-counter, output registers, two saturating counters.
// TESTING
//  Post-reset, opcode 01 accepted at T, out_ready=1 -> ula_en T+1 only, op=000, out_valid T+2, instr_count=1.
//  Opcode 04 (LAT_DIV=8), out_ready low 3 cycles -> ula_en T+1..T+8 op=011, out_valid held T+9..T+12.
//  Opcode 8'h07 -> no ula_en, out_valid+out_err at T+1, op=111, err_count=1 after handshake.
//  abort during 3rd EXEC cycle of MUL -> IDLE next edge, no token, counters unchanged, then ADD completes.
//  abort with in_valid in IDLE -> not accepted; abort with out_ready in DONE -> no count.
//  CNT_W=2, 5 back-to-back SUBs -> instr_count saturates at 3; async reset mid-EXEC -> all outputs reset.

Source files
------------

// File: rtl/ula_op_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ula_op_sequencer_pkg
// Description : Shared opcode constants, ULA operation codes, decoder result
//               type and default latencies for the ULA operation sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package ula_op_sequencer_pkg;

    // Low-3-bit opcode encodings accepted by the decoder (upper bits must be 0)
    localparam logic [2:0] c_opc_add = 3'd1;
    localparam logic [2:0] c_opc_sub = 3'd2;
    localparam logic [2:0] c_opc_mul = 3'd3;
    localparam logic [2:0] c_opc_div = 3'd4;
    localparam logic [2:0] c_opc_mod = 3'd5;

    // Default ULA-enable cycle counts per operation class
    localparam int c_def_lat_addsub = 1;
    localparam int c_def_lat_mul    = 4;
    localparam int c_def_lat_div    = 8;

    typedef enum logic [2:0] {
        ULA_ADD     = 3'b000,
        ULA_SUB     = 3'b001,
        ULA_MUL     = 3'b010,
        ULA_DIV     = 3'b011,
        ULA_MOD     = 3'b100,
        ULA_ILLEGAL = 3'b111
    } ula_op_e;

    // Which latency parameter governs an operation
    typedef enum logic [1:0] {
        LAT_SEL_ADDSUB = 2'd0,
        LAT_SEL_MUL    = 2'd1,
        LAT_SEL_DIV    = 2'd2
    } lat_sel_e;

    typedef struct packed {
        ula_op_e  op;
        logic     legal;
        lat_sel_e lat_sel;
    } dec_t;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ula_op_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : ula_op_sequencer_if
// Description : Instruction handshake, ULA control, completion token and
//               performance-counter bundle of the ULA operation sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
interface ula_op_sequencer_if #(
    parameter int OPCODE_W = 8,
    parameter int CNT_W    = 16
);
    logic                in_valid;
    logic [OPCODE_W-1:0] in_opcode;
    logic                in_ready;
    logic                abort;
    logic [2:0]          ula_operation;
    logic                ula_en;
    logic                out_valid;
    logic                out_err;
    logic                out_ready;
    logic                busy;
    logic [CNT_W-1:0]    instr_count;
    logic [CNT_W-1:0]    err_count;

    // Fetch/consumer side
    modport master (
        output in_valid, in_opcode, abort, out_ready,
        input  in_ready, ula_operation, ula_en, out_valid, out_err,
               busy, instr_count, err_count
    );

    // Sequencer side
    modport slave (
        input  in_valid, in_opcode, abort, out_ready,
        output in_ready, ula_operation, ula_en, out_valid, out_err,
               busy, instr_count, err_count
    );
endinterface
`default_nettype wire

// File: rtl/ula_op_sequencer_decoder.sv
`default_nettype none
// ============================================================================
// Module      : ula_op_decoder
// Description : Combinational opcode decoder: opcode -> {ULA op, legal,
//               latency class}. Any set bit above bit 2 makes it illegal.
// Revision    : 1.0 - initial release
// ============================================================================
module ula_op_decoder
    import ula_op_sequencer_pkg::*;
#(
    parameter int OPCODE_W = 8
) (
    input  wire logic [OPCODE_W-1:0] i_opcode,
    output dec_t                     o_dec
);

    logic w_upper_zero;

    assign w_upper_zero = ((i_opcode >> 3) == '0);

    // Map legal encodings; everything else falls through to the illegal code
    always_comb begin
        o_dec = '{op: ULA_ILLEGAL, legal: 1'b0, lat_sel: LAT_SEL_ADDSUB};
        if (w_upper_zero) begin
            case (i_opcode[2:0])
                c_opc_add: o_dec = '{op: ULA_ADD, legal: 1'b1, lat_sel: LAT_SEL_ADDSUB};
                c_opc_sub: o_dec = '{op: ULA_SUB, legal: 1'b1, lat_sel: LAT_SEL_ADDSUB};
                c_opc_mul: o_dec = '{op: ULA_MUL, legal: 1'b1, lat_sel: LAT_SEL_MUL};
                c_opc_div: o_dec = '{op: ULA_DIV, legal: 1'b1, lat_sel: LAT_SEL_DIV};
                c_opc_mod: o_dec = '{op: ULA_MOD, legal: 1'b1, lat_sel: LAT_SEL_DIV};
                default:   o_dec = '{op: ULA_ILLEGAL, legal: 1'b0, lat_sel: LAT_SEL_ADDSUB};
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/ula_op_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : ula_op_sequencer
// Description : Accepts one instruction per handshake, holds the ULA enabled
//               for the operation's latency, then presents a completion token.
//               Keeps saturating completed/error token counters.
// Revision    : 1.0 - initial release
// ============================================================================
module ula_op_sequencer
    import ula_op_sequencer_pkg::*;
#(
    parameter int OPCODE_W   = 8,
    parameter int LAT_ADDSUB = c_def_lat_addsub,
    parameter int LAT_MUL    = c_def_lat_mul,
    parameter int LAT_DIV    = c_def_lat_div,
    parameter int CNT_W      = 16
) (
    input wire logic           clk,
    input wire logic           reset,
    ula_op_sequencer_if.slave  bus
);

    localparam int c_lat_max = max3(LAT_ADDSUB, LAT_MUL, LAT_DIV);
    // Down-counter holds LAT-1, so clog2(max latency) bits suffice
    localparam int c_cyc_w   = (c_lat_max > 1) ? $clog2(c_lat_max) : 1;

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_exec = 2'd1;
    localparam logic [1:0] c_st_done = 2'd2;

    logic [1:0]         r_state;
    logic [2:0]         r_op;
    logic               r_en;
    logic               r_valid;
    logic               r_err;
    logic [c_cyc_w-1:0] r_cyc;
    logic [CNT_W-1:0]   r_instr_cnt;
    logic [CNT_W-1:0]   r_err_cnt;

    dec_t               w_dec;
    logic [c_cyc_w-1:0] w_lat_m1;
    logic               w_handshake;

    ula_op_decoder #(
        .OPCODE_W (OPCODE_W)
    ) u_dec (
        .i_opcode (bus.in_opcode),
        .o_dec    (w_dec)
    );

    // Counter preload for the decoded operation's latency class
    always_comb begin
        w_lat_m1 = c_cyc_w'(LAT_ADDSUB - 1);
        case (w_dec.lat_sel)
            LAT_SEL_MUL: w_lat_m1 = c_cyc_w'(LAT_MUL - 1);
            LAT_SEL_DIV: w_lat_m1 = c_cyc_w'(LAT_DIV - 1);
            default:     w_lat_m1 = c_cyc_w'(LAT_ADDSUB - 1);
        endcase
    end

    // Token consumed this edge; abort suppresses the count
    assign w_handshake = (r_state == c_st_done) && bus.out_ready && !bus.abort;

    // Sequencer FSM with its registered outputs; abort flushes from any state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= c_st_idle;
            r_op    <= ULA_ILLEGAL;
            r_en    <= 1'b0;
            r_valid <= 1'b0;
            r_err   <= 1'b0;
            r_cyc   <= '0;
        end else if (bus.abort) begin
            r_state <= c_st_idle;
            r_op    <= ULA_ILLEGAL;
            r_en    <= 1'b0;
            r_valid <= 1'b0;
            r_err   <= 1'b0;
            r_cyc   <= '0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (bus.in_valid) begin
                        if (w_dec.legal) begin
                            r_state <= c_st_exec;
                            r_op    <= w_dec.op;
                            r_en    <= 1'b1;
                            r_cyc   <= w_lat_m1;
                        end else begin
                            // Illegal opcodes skip the ULA entirely
                            r_state <= c_st_done;
                            r_op    <= ULA_ILLEGAL;
                            r_valid <= 1'b1;
                            r_err   <= 1'b1;
                        end
                    end
                end
                c_st_exec: begin
                    if (r_cyc == '0) begin
                        r_state <= c_st_done;
                        r_en    <= 1'b0;
                        r_valid <= 1'b1;
                    end else begin
                        r_cyc <= r_cyc - c_cyc_w'(1);
                    end
                end
                c_st_done: begin
                    if (bus.out_ready) begin
                        r_state <= c_st_idle;
                        r_op    <= ULA_ILLEGAL;
                        r_valid <= 1'b0;
                        r_err   <= 1'b0;
                    end
                end
                default: begin
                    r_state <= c_st_idle;
                    r_op    <= ULA_ILLEGAL;
                    r_en    <= 1'b0;
                    r_valid <= 1'b0;
                    r_err   <= 1'b0;
                    r_cyc   <= '0;
                end
            endcase
        end
    end

    // Saturating performance counters, bumped on each completed token
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_instr_cnt <= '0;
            r_err_cnt   <= '0;
        end else if (w_handshake) begin
            if (r_instr_cnt != '1) begin
                r_instr_cnt <= r_instr_cnt + CNT_W'(1);
            end
            if (r_err && (r_err_cnt != '1)) begin
                r_err_cnt <= r_err_cnt + CNT_W'(1);
            end
        end
    end

    assign bus.in_ready      = (r_state == c_st_idle);
    assign bus.busy          = (r_state != c_st_idle);
    assign bus.ula_operation = r_op;
    assign bus.ula_en        = r_en;
    assign bus.out_valid     = r_valid;
    assign bus.out_err       = r_err;
    assign bus.instr_count   = r_instr_cnt;
    assign bus.err_count     = r_err_cnt;

endmodule
`default_nettype wire

// File: tb/tb_ula_op_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_ula_op_sequencer
// Description : Self-checking bench for ula_op_sequencer: decode table,
//               hand-written abort/reset/saturation sequences and random
//               traffic against a timestamp-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ula_op_sequencer;

    localparam int LAT_ADDSUB = 1;
    localparam int LAT_MUL    = 4;
    localparam int LAT_DIV    = 8;
    localparam int SAT_MAX    = 3;
    localparam int CNT_MAX    = 65535;

    logic clk = 1'b0;
    logic reset = 1'b1;

    always #5 clk = ~clk;

    ula_op_sequencer_if #(.OPCODE_W(8), .CNT_W(16)) bus ();
    ula_op_sequencer_if #(.OPCODE_W(8), .CNT_W(2))  bus2 ();

    // The narrow-counter instance sees exactly the same traffic
    assign bus2.in_valid  = bus.in_valid;
    assign bus2.in_opcode = bus.in_opcode;
    assign bus2.abort     = bus.abort;
    assign bus2.out_ready = bus.out_ready;

    ula_op_sequencer #(
        .OPCODE_W(8), .LAT_ADDSUB(LAT_ADDSUB), .LAT_MUL(LAT_MUL),
        .LAT_DIV(LAT_DIV), .CNT_W(16)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    ula_op_sequencer #(
        .OPCODE_W(8), .LAT_ADDSUB(LAT_ADDSUB), .LAT_MUL(LAT_MUL),
        .LAT_DIV(LAT_DIV), .CNT_W(2)
    ) dut_sat (
        .clk   (clk),
        .reset (reset),
        .bus   (bus2)
    );

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    // Reference model: one in-flight instruction described by its accept
    // cycle and latency; outputs follow from cycle arithmetic.
    bit         m_act   = 1'b0;
    int         m_tacc  = 0;
    int         m_lat   = 0;
    bit         m_legal = 1'b0;
    logic [2:0] m_op    = 3'b111;
    int         m_icnt  = 0;
    int         m_ecnt  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int lat_of(input logic [7:0] opc);
        case (opc)
            8'd1, 8'd2: return LAT_ADDSUB;
            8'd3:       return LAT_MUL;
            8'd4, 8'd5: return LAT_DIV;
            default:    return 0;
        endcase
    endfunction

    function automatic bit m_exec();
        return m_act && m_legal && (cyc >= m_tacc + 1) && (cyc <= m_tacc + m_lat);
    endfunction

    function automatic bit m_done();
        return m_act && (cyc >= m_tacc + (m_legal ? m_lat + 1 : 1));
    endfunction

    function automatic int sat(input int v);
        return (v > SAT_MAX) ? SAT_MAX : v;
    endfunction

    // Advance the model across the coming clock edge
    task automatic model_edge(input bit iv, input logic [7:0] opc, input bit ab, input bit ordy);
        if (ab) begin
            m_act = 1'b0;
        end else if (!m_act) begin
            if (iv) begin
                m_act   = 1'b1;
                m_tacc  = cyc;
                m_lat   = lat_of(opc);
                m_legal = (m_lat != 0);
                m_op    = opc[2:0] - 3'd1;
            end
        end else if (m_done() && ordy) begin
            m_act = 1'b0;
            if (m_icnt < CNT_MAX) m_icnt++;
            if (!m_legal && m_ecnt < CNT_MAX) m_ecnt++;
        end
    endtask

    task automatic check_all();
        chk("in_ready", bus.in_ready, !m_act);
        chk("busy", bus.busy, m_act);
        chk("ula_en", bus.ula_en, m_exec());
        chk("out_valid", bus.out_valid, m_done());
        if (m_done()) chk("out_err", bus.out_err, !m_legal);
        if (m_exec()) chk("ula_operation", bus.ula_operation, m_op);
        else if (m_done() && !m_legal) chk("ula_operation_illegal", bus.ula_operation, 3'b111);
        chk("instr_count", bus.instr_count, m_icnt);
        chk("err_count", bus.err_count, m_ecnt);
        chk("sat_instr_count", bus2.instr_count, sat(m_icnt));
        chk("sat_err_count", bus2.err_count, sat(m_ecnt));
    endtask

    // One clock: drive inputs, update model, check after the edge
    task automatic step(input bit iv, input logic [7:0] opc, input bit ab, input bit ordy);
        bus.in_valid  = iv;
        bus.in_opcode = opc;
        bus.abort     = ab;
        bus.out_ready = ordy;
        model_edge(iv, opc, ab, ordy);
        @(posedge clk);
        cyc++;
        @(negedge clk);
        check_all();
    endtask

    // Accept one instruction and observe it through to its handshake;
    // out_ready rises once out_valid has been seen for hold+1 cycles.
    task automatic run_txn(input logic [7:0] opc, input int hold,
                           output int en_cnt, output int vld_first, output int vld_len,
                           output bit err_seen, output logic [2:0] op_seen);
        int t;
        bit fin;
        en_cnt    = 0;
        vld_first = -1;
        vld_len   = 0;
        err_seen  = 1'b0;
        op_seen   = 3'bxxx;
        fin       = 1'b0;
        t = cyc;
        step(1'b1, opc, 1'b0, 1'b0);
        for (int k = 0; k < 40 && !fin; k++) begin
            if (bus.ula_en) begin
                if (en_cnt == 0) op_seen = bus.ula_operation;
                en_cnt++;
            end
            if (bus.out_valid) begin
                if (vld_len == 0) begin
                    vld_first = cyc - t;
                    err_seen  = bus.out_err;
                    if (en_cnt == 0) op_seen = bus.ula_operation;
                end
                vld_len++;
            end
            if (bus.out_valid && vld_len > hold) begin
                step(1'b0, 8'h00, 1'b0, 1'b1);
                fin = 1'b1;
            end else begin
                step(1'b0, 8'h00, 1'b0, 1'b0);
            end
        end
        chk("txn_completed", fin, 1'b1);
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_ula_operation"}, bus.ula_operation, 3'b111);
        chk({tag, "_ula_en"}, bus.ula_en, 1'b0);
        chk({tag, "_out_valid"}, bus.out_valid, 1'b0);
        chk({tag, "_out_err"}, bus.out_err, 1'b0);
        chk({tag, "_in_ready"}, bus.in_ready, 1'b1);
        chk({tag, "_busy"}, bus.busy, 1'b0);
        chk({tag, "_instr_count"}, bus.instr_count, 0);
        chk({tag, "_err_count"}, bus.err_count, 0);
        chk({tag, "_sat_instr_count"}, bus2.instr_count, 0);
    endtask

    typedef struct {
        logic [7:0] opc;
        int         hold;
        int         en_cnt;
        int         vld_first;
        int         vld_len;
        bit         err;
        logic [2:0] op;
    } vec_t;

    vec_t tbl[9];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int en_cnt, vld_first, vld_len;
        bit err_seen;
        logic [2:0] op_seen;
        int save_i, save_e;
        int r;
        logic [7:0] opc;

        tbl[0] = '{8'h01, 0, LAT_ADDSUB, LAT_ADDSUB + 1, 1, 1'b0, 3'b000};
        tbl[1] = '{8'h02, 1, LAT_ADDSUB, LAT_ADDSUB + 1, 2, 1'b0, 3'b001};
        tbl[2] = '{8'h03, 0, LAT_MUL,    LAT_MUL + 1,    1, 1'b0, 3'b010};
        tbl[3] = '{8'h04, 3, LAT_DIV,    LAT_DIV + 1,    4, 1'b0, 3'b011};
        tbl[4] = '{8'h05, 0, LAT_DIV,    LAT_DIV + 1,    1, 1'b0, 3'b100};
        tbl[5] = '{8'h07, 0, 0,          1,              1, 1'b1, 3'b111};
        tbl[6] = '{8'h00, 2, 0,          1,              3, 1'b1, 3'b111};
        tbl[7] = '{8'h06, 0, 0,          1,              1, 1'b1, 3'b111};
        tbl[8] = '{8'h81, 0, 0,          1,              1, 1'b1, 3'b111};

        bus.in_valid  = 1'b0;
        bus.in_opcode = 8'h00;
        bus.abort     = 1'b0;
        bus.out_ready = 1'b0;

        // Reset held across edges
        @(negedge clk);
        @(negedge clk);
        check_reset_state("reset");
        reset = 1'b0;
        check_all();

        // Decode table: one full transaction per opcode
        foreach (tbl[i]) begin
            run_txn(tbl[i].opc, tbl[i].hold, en_cnt, vld_first, vld_len, err_seen, op_seen);
            chk($sformatf("tbl%0d_en_cycles", i), en_cnt, tbl[i].en_cnt);
            chk($sformatf("tbl%0d_valid_first", i), vld_first, tbl[i].vld_first);
            chk($sformatf("tbl%0d_valid_len", i), vld_len, tbl[i].vld_len);
            chk($sformatf("tbl%0d_err", i), err_seen, tbl[i].err);
            chk($sformatf("tbl%0d_op", i), op_seen, tbl[i].op);
        end
        chk("tbl_instr_count", bus.instr_count, 9);
        chk("tbl_err_count", bus.err_count, 4);

        // Abort during the 3rd EXEC cycle of a MUL, then an ADD completes
        save_i = m_icnt;
        save_e = m_ecnt;
        step(1'b1, 8'h03, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0);
        chk("mul_third_exec_en", bus.ula_en, 1'b1);
        step(1'b0, 8'h00, 1'b1, 1'b1);
        chk("abort_exec_en", bus.ula_en, 1'b0);
        chk("abort_exec_busy", bus.busy, 1'b0);
        chk("abort_exec_op", bus.ula_operation, 3'b111);
        for (int k = 0; k < 6; k++) step(1'b0, 8'h00, 1'b0, 1'b1);
        chk("abort_exec_no_count", bus.instr_count, save_i);
        chk("abort_exec_no_err", bus.err_count, save_e);
        run_txn(8'h01, 0, en_cnt, vld_first, vld_len, err_seen, op_seen);
        chk("post_abort_add_en", en_cnt, 1);
        chk("post_abort_add_valid", vld_first, 2);
        chk("post_abort_add_count", bus.instr_count, save_i + 1);

        // Abort beats an IDLE accept
        step(1'b1, 8'h01, 1'b1, 1'b0);
        chk("abort_idle_busy", bus.busy, 1'b0);
        chk("abort_idle_en", bus.ula_en, 1'b0);

        // Abort with out_ready in DONE: token dropped, nothing counted
        save_i = m_icnt;
        save_e = m_ecnt;
        step(1'b1, 8'h07, 1'b0, 1'b0);
        chk("illegal_valid", bus.out_valid, 1'b1);
        chk("illegal_err", bus.out_err, 1'b1);
        step(1'b0, 8'h00, 1'b1, 1'b1);
        chk("abort_done_valid", bus.out_valid, 1'b0);
        chk("abort_done_count", bus.instr_count, save_i);
        chk("abort_done_err_count", bus.err_count, save_e);

        // Async reset in the middle of a DIV
        step(1'b1, 8'h04, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0);
        #1;
        reset = 1'b1;
        #1;
        check_reset_state("async_reset");
        m_act  = 1'b0;
        m_icnt = 0;
        m_ecnt = 0;
        bus.in_valid  = 1'b0;
        bus.abort     = 1'b0;
        bus.out_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        check_all();

        // Back-to-back SUBs drive the 2-bit counters into saturation
        for (int k = 1; k <= 5; k++) begin
            run_txn(8'h02, 0, en_cnt, vld_first, vld_len, err_seen, op_seen);
            chk($sformatf("sub%0d_count", k), bus.instr_count, k);
            chk($sformatf("sub%0d_sat_count", k), bus2.instr_count, (k > 3) ? 3 : k);
        end

        // Random traffic, including opcode churn while busy
        for (int k = 0; k < 1500; k++) begin
            r = $urandom_range(0, 15);
            if (r < 11)       opc = 8'($urandom_range(1, 5));
            else if (r == 11) opc = 8'h00;
            else if (r == 12) opc = 8'h06;
            else if (r == 13) opc = 8'h07;
            else if (r == 14) opc = 8'h80 | 8'($urandom_range(1, 5));
            else              opc = 8'($urandom_range(0, 255));
            step($urandom_range(0, 9) < 7, opc, $urandom_range(0, 31) == 0,
                 $urandom_range(0, 9) < 6);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
